tt_core_sequencer: RTL

Byte-serial front end that sequences single_cycle_datapath behind the 8-bit TinyTapeout pins.
- Assembles a 32-bit instruction from four 8-bit transfers.
- Steps the core exactly once per instruction via a one-cycle enable.
- Captures the 32-bit ALU result and streams it back out as four bytes.
- Sits between the top-level pin wrapper and the datapath, replacing the direct ui_in-to-instr hookup.

---
 rtl/tt_core_pkg.sv | 22 ++
 rtl/tt_core_sequencer_byte_serializer.sv | 55 +++++
 rtl/tt_core_sequencer.sv | 110 +++++++++++
 3 files changed

// File: rtl/tt_core_pkg.sv
// Shared types and constants for the byte-serial core sequencer.
// Holds the sequencer state encoding and the default widths.
package tt_core_pkg;

  localparam int XLEN   = 32;
  localparam int BYTE_W = 8;
  localparam int NBYTES = XLEN / BYTE_W;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    EXEC  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // A one-byte word still needs a 1-bit index so the counters stay declarable.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W = idx_w(NBYTES);

endpackage

// File: rtl/tt_core_sequencer_byte_serializer.sv
// Holds a captured XLEN-wide result and streams it out LSB byte first
// over a valid/ready handshake.
module tt_core_sequencer_byte_serializer #(
  parameter int XLEN   = tt_core_pkg::XLEN,
  parameter int BYTE_W = tt_core_pkg::BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              arm,
  input  logic [XLEN-1:0]   data,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] byte_out,
  output logic              out_valid,
  output logic              last_beat
);

  localparam int NBYTES = XLEN / BYTE_W;
  localparam int IDX_W  = tt_core_pkg::idx_w(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  logic [XLEN-1:0]  data_q;
  logic [IDX_W-1:0] oidx;

  assign last_beat = out_valid && out_ready && (oidx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      oidx      <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      // The result is always captured; arm decides whether it is streamed.
      data_q    <= data;
      oidx      <= '0;
      out_valid <= arm;
    end else if (out_valid && out_ready) begin
      if (last_beat) begin
        oidx      <= '0;
        out_valid <= 1'b0;
      end else begin
        oidx <= oidx + IDX_W'(1);
      end
    end
  end

  // data_q and oidx only move on a beat, so byte_out is stable while stalled.
  always_comb begin
    byte_out = '0;
    for (int b = 0; b < NBYTES; b++) begin
      if (oidx == IDX_W'(b)) byte_out = data_q[b*BYTE_W +: BYTE_W];
    end
  end

endmodule

// File: rtl/tt_core_sequencer.sv
// Byte-serial front end for the single-cycle datapath: loads an instruction
// byte by byte, steps the core once, then streams the ALU result back out.
module tt_core_sequencer #(
  parameter int XLEN     = tt_core_pkg::XLEN,
  parameter int BYTE_W   = tt_core_pkg::BYTE_W,
  parameter bit DRAIN_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [XLEN-1:0]   instr,
  output logic              core_step,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              core_we,
  output logic [BYTE_W-1:0] byte_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              we_flag,
  output logic [15:0]       instr_count,
  output logic              busy
);

  import tt_core_pkg::state_t;
  import tt_core_pkg::LOAD;
  import tt_core_pkg::EXEC;
  import tt_core_pkg::DRAIN;

  localparam int NBYTES = XLEN / BYTE_W;
  localparam int IDX_W  = tt_core_pkg::idx_w(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [XLEN-1:0]  shadow;
  logic [XLEN-1:0]  shadow_next;
  logic             beat;
  logic             drain_done;

  assign byte_ready = (state == LOAD);
  assign busy       = (state != LOAD);
  assign beat       = byte_valid && byte_ready;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    shadow_next = shadow;
    for (int b = 0; b < NBYTES; b++) begin
      if (idx == IDX_W'(b)) shadow_next[b*BYTE_W +: BYTE_W] = byte_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD;
      idx         <= '0;
      shadow      <= '0;
      instr       <= '0;
      core_step   <= 1'b0;
      we_flag     <= 1'b0;
      instr_count <= '0;
    end else begin
      core_step <= 1'b0;
      case (state)
        LOAD: begin
          if (beat) begin
            shadow <= shadow_next;
            if (idx == LAST_IDX) begin
              idx       <= '0;
              instr     <= shadow_next;
              core_step <= 1'b1;
              state     <= EXEC;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        EXEC: begin
          // The core commits on this same edge; record its side effects.
          we_flag     <= core_we;
          instr_count <= instr_count + 16'd1;
          state       <= DRAIN_EN ? DRAIN : LOAD;
        end
        DRAIN: begin
          if (drain_done) state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

  tt_core_sequencer_byte_serializer #(
    .XLEN   (XLEN),
    .BYTE_W (BYTE_W)
  ) u_serializer (
    .clk       (clk),
    .rst       (rst),
    .load      (state == EXEC),
    .arm       (DRAIN_EN),
    .data      (alu_result),
    .out_ready (out_ready),
    .byte_out  (byte_out),
    .out_valid (out_valid),
    .last_beat (drain_done)
  );

endmodule
